// File: rtl/serial_demux_pkg.sv
// serial_demux_pkg
// Shared definitions for the serial demultiplexer slice: default widths used
// by the cipher top level, a constant clog2 helper and the serializer state
// type. No ports; imported by sync_fifo and serial_demux.
package serial_demux_pkg;

  // Defaults shared with the cipher top level so both agree on the datapath shape.
  localparam int DEF_MST_DWIDTH = 32;
  localparam int DEF_SYS_DWIDTH = 8;
  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_FIFO_DEPTH = 2;

  // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // IDLE waits for a buffered word, SHIFT presents beats of the current word.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_demux_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with asynchronous active-high reset. Pointers carry one
// extra wrap bit so full and empty can be told apart without a counter.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   i_push    in   write request (ignored while full)
//   i_wrData  in   WIDTH-bit write data
//   i_pop     in   read request (ignored while empty)
//   o_rdData  out  WIDTH-bit head entry (valid while not empty)
//   o_full    out  FIFO holds DEPTH entries
//   o_empty   out  FIFO holds no entries
module sync_fifo
  import serial_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdData,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_doPush;
  logic             w_doPop;

  // Requests against a full or empty FIFO are dropped here so callers can
  // drive push/pop without re-checking the flags themselves.
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Storage array; cleared on reset so the head is never undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_doPush) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
    end
  end

  // Pointers wrap naturally through their extra MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // Same index with differing wrap bits means the writer lapped the reader.
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_rdData = r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/serial_demux.sv
// serial_demux
// Width-converting demultiplexer: accepts MST_DWIDTH-bit words with a channel
// select, buffers them, and emits SYS_DWIDTH-bit beats MSB first on the
// selected channel with per-channel valid/ready flow control.
// Ports:
//   clk_sys  in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   select   in   destination channel, captured with data_i on accept
//   data_i   in   input word
//   valid_i  in   input word valid
//   ready_o  out  a word can be accepted this cycle
//   data_o   out  channel c beat on [c*SYS_DWIDTH +: SYS_DWIDTH]
//   valid_o  out  per-channel beat valid
//   ready_i  in   per-channel beat ready
//   drop_o   out  one-cycle pulse after a word with an out-of-range select
//   busy_o   out  FIFO non-empty or a word is being serialized
module serial_demux
  import serial_demux_pkg::*;
#(
  parameter  int MST_DWIDTH = DEF_MST_DWIDTH,
  parameter  int SYS_DWIDTH = DEF_SYS_DWIDTH,
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int RATIO      = MST_DWIDTH / SYS_DWIDTH,
  localparam int SEL_W      = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             select,
  input  logic [MST_DWIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [NUM_CH*SYS_DWIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            valid_o,
  input  logic [NUM_CH-1:0]            ready_i,
  output logic                         drop_o,
  output logic                         busy_o
);

  localparam int                 CNT_W      = (clog2(RATIO) > 1) ? clog2(RATIO) : 1;
  localparam int                 ENTRY_W    = SEL_W + MST_DWIDTH;
  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(RATIO - 1);
  localparam logic [SEL_W:0]     NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [MST_DWIDTH-1:0]   r_shiftReg;
  logic [SEL_W-1:0]        r_ch;
  logic [CNT_W-1:0]        r_beatCnt;
  logic                    r_outOfReset;
  logic                    r_drop;
  logic                    w_accept;
  logic                    w_selOk;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_advance;
  logic                    w_fifoFull;
  logic                    w_fifoEmpty;
  logic [ENTRY_W-1:0]      w_fifoRd;

  // Out-of-range selects are still accepted (the master is not stalled) but
  // never written, so they can never reach a channel.
  assign w_accept = valid_i && ready_o;
  assign w_selOk  = ({1'b0, select} < NUM_CH_EXT);
  assign w_push   = w_accept && w_selOk;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_sys),
    .rst      (rst),
    .i_push   (w_push),
    .i_wrData ({select, data_i}),
    .i_pop    (w_pop),
    .o_rdData (w_fifoRd),
    .o_full   (w_fifoFull),
    .o_empty  (w_fifoEmpty)
  );

  // ready_o must stay low throughout reset and only rise on the first edge
  // after release, so a flag records that an edge has been seen.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_outOfReset <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_outOfReset <= 1'b1;
      r_drop       <= w_accept && !w_selOk;
    end
  end

  // There is no bypass: a pop in the same cycle does not make room while full.
  assign ready_o = r_outOfReset && !w_fifoFull;
  assign drop_o  = r_drop;
  assign busy_o  = !w_fifoEmpty || (r_state == SHIFT);

  // Serializer state register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. On the last beat the next word is popped straight into
  // the shift register, so consecutive words stream without a bubble even
  // when they target different channels.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifoEmpty) begin
          w_pop       = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (ready_i[r_ch]) begin
          w_advance = 1'b1;
          if (r_beatCnt == '0) begin
            if (!w_fifoEmpty) begin
              w_pop = 1'b1;
            end else begin
              w_nextState = IDLE;
            end
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: a pop loads word, channel and beat count together; an accepted
  // beat otherwise shifts the next beat into the MSB position.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_shiftReg <= '0;
      r_ch       <= '0;
      r_beatCnt  <= '0;
    end else if (w_pop) begin
      r_shiftReg <= w_fifoRd[MST_DWIDTH-1:0];
      r_ch       <= w_fifoRd[ENTRY_W-1 -: SEL_W];
      r_beatCnt  <= LAST_BEAT;
    end else if (w_advance) begin
      r_shiftReg <= r_shiftReg << SYS_DWIDTH;
      if (r_beatCnt != '0) begin
        r_beatCnt <= r_beatCnt - 1'b1;
      end
    end
  end

  // Output steering. Outputs derive only from registered state, so a beat
  // stays stable until its handshake and everything returns to zero as soon
  // as reset is asserted.
  always_comb begin
    valid_o = '0;
    data_o  = '0;
    if (r_state == SHIFT) begin
      valid_o[r_ch]                           = 1'b1;
      data_o[r_ch*SYS_DWIDTH +: SYS_DWIDTH]   = r_shiftReg[MST_DWIDTH-1 -: SYS_DWIDTH];
    end
  end

endmodule

// File: tb/tb_serial_demux.sv
// tb_serial_demux
// Self-checking bench for serial_demux at default parameters. A scoreboard
// queue holds the beats each accepted word should produce; a negedge monitor
// compares outputs against the queue head and checks beat stability.
module tb_serial_demux;

  localparam int NCH = 3;

  logic        clk_sys;
  logic        rst;
  logic [1:0]  select;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [23:0] data_o;
  logic [2:0]  valid_o;
  logic [2:0]  ready_i;
  logic        drop_o;
  logic        busy_o;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] word;
    logic        expDrop;
  } vec_t;

  beat_t       expQ[$];
  int          hsLog[$];
  int          cycleCnt = 0;
  int          checks   = 0;
  int          errors   = 0;
  beat_t       monHead;
  logic        prevHeld;
  logic [2:0]  prevValid;
  logic [23:0] prevData;

  serial_demux dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .select  (select),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .drop_o  (drop_o),
    .busy_o  (busy_o)
  );

  // Free-running clock, first rising edge at t=5.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Edge counter used to measure latency and beat contiguity.
  always @(posedge clk_sys) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Expected beats of a word, MSB beat first.
  task automatic pushWord(input logic [1:0] sel, input logic [31:0] word);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.ch   = sel;
      b.data = word[31-8*i -: 8];
      expQ.push_back(b);
    end
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] word, output int acceptCycle);
    int guard;
    guard       = 0;
    acceptCycle = -1;
    select      = sel;
    data_i      = word;
    valid_i     = 1'b1;
    while (!ready_o && guard < 50) begin
      @(posedge clk_sys);
      #1;
      guard++;
    end
    if (!ready_o) begin
      valid_i = 1'b0;
      reportTimeout("acceptWait");
      return;
    end
    @(posedge clk_sys);
    #1;
    valid_i     = 1'b0;
    acceptCycle = cycleCnt;
    if (sel < NCH) pushWord(sel, word);
  endtask

  // Waits for the scoreboard to empty, then requires the block to be idle.
  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(posedge clk_sys);
      #2;
      guard++;
    end
    if (expQ.size() != 0) reportTimeout(name);
    else checkOutput({name, "Busy"}, busy_o, 0);
  endtask

  // Monitor: compares outputs against the scoreboard head, pops it on a
  // handshake and requires an unaccepted beat to be held unchanged.
  always @(negedge clk_sys) begin
    if (rst) begin
      prevHeld = 1'b0;
    end else begin
      if (prevHeld) begin
        checkOutput("holdValid", valid_o, prevValid);
        checkOutput("holdData", data_o, prevData);
      end
      if (expQ.size() == 0) begin
        checkOutput("idleValid", valid_o, 0);
        checkOutput("idleData", data_o, 0);
      end else begin
        monHead = expQ[0];
        checkOutput("otherValid", valid_o & ~(3'b001 << monHead.ch), 0);
        if (valid_o[monHead.ch]) begin
          checkOutput("beatData", data_o[monHead.ch*8 +: 8], monHead.data);
          checkOutput("otherData", data_o & ~(24'hFF << (monHead.ch*8)), 0);
          if (ready_i[monHead.ch]) begin
            void'(expQ.pop_front());
            hsLog.push_back(cycleCnt);
          end
        end
      end
      prevHeld  = |(valid_o & ~ready_i);
      prevValid = valid_o;
      prevData  = data_o;
    end
  end

  initial begin
    vec_t vecs[5];
    int   acc;
    int   accepted;
    int   guard;
    logic prevRdy;
    logic [31:0] fullWords[6];

    vecs[0] = '{2'd1, 32'hA1B2C3D4, 1'b0};
    vecs[1] = '{2'd0, 32'h0F1E2D3C, 1'b0};
    vecs[2] = '{2'd2, 32'h80000001, 1'b0};
    vecs[3] = '{2'd3, 32'hCAFEF00D, 1'b1};
    vecs[4] = '{2'd1, 32'hFFFF00FF, 1'b0};

    rst     = 1'b1;
    select  = '0;
    data_i  = '0;
    valid_i = 1'b0;
    ready_i = 3'b111;

    // Reset values.
    #2;
    checkOutput("rstValid", valid_o, 0);
    checkOutput("rstData", data_o, 0);
    checkOutput("rstDrop", drop_o, 0);
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstReady", ready_o, 0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    checkOutput("readyBeforeEdge", ready_o, 0);
    @(posedge clk_sys);
    #1;
    checkOutput("readyAfterEdge", ready_o, 1);

    // Table-driven single words, all channels ready.
    for (int i = 0; i < 5; i++) begin
      hsLog.delete();
      applyStimulus(vecs[i].sel, vecs[i].word, acc);
      checkOutput($sformatf("drop%0d", i), drop_o, vecs[i].expDrop);
      if (vecs[i].expDrop) begin
        checkOutput($sformatf("dropBusy%0d", i), busy_o, 0);
        @(posedge clk_sys);
        #1;
        checkOutput($sformatf("dropPulseEnd%0d", i), drop_o, 0);
        checkOutput($sformatf("dropBusyLater%0d", i), busy_o, 0);
        @(posedge clk_sys);
        #1;
      end else begin
        checkOutput($sformatf("busyAfterAccept%0d", i), busy_o, 1);
        waitDrain($sformatf("vec%0d", i));
        checkOutput($sformatf("beats%0d", i), hsLog.size(), 4);
        if (hsLog.size() == 4) begin
          checkOutput($sformatf("latency%0d", i), hsLog[0] - acc, 1);
          checkOutput($sformatf("lastBeat%0d", i), hsLog[3] - acc, 4);
        end
      end
    end

    // Back-to-back words with a channel switch must stream without a gap.
    hsLog.delete();
    applyStimulus(2'd0, 32'h11223344, acc);
    applyStimulus(2'd2, 32'h55667788, acc);
    waitDrain("b2b");
    checkOutput("b2bBeats", hsLog.size(), 8);
    if (hsLog.size() == 8) checkOutput("b2bSpan", hsLog[7] - hsLog[0], 7);

    // Alternating backpressure on channel 1.
    hsLog.delete();
    ready_i = 3'b101;
    applyStimulus(2'd1, 32'hDEADBEEF, acc);
    guard = 0;
    while (expQ.size() != 0 && guard < 100) begin
      @(posedge clk_sys);
      #1;
      ready_i[1] = ~ready_i[1];
      guard++;
    end
    ready_i = 3'b111;
    waitDrain("bp");
    checkOutput("bpBeats", hsLog.size(), 4);
    if (hsLog.size() == 4) checkOutput("bpSpan", hsLog[3] - hsLog[0], 6);

    // Stalled output: only FIFO_DEPTH+1 words fit.
    hsLog.delete();
    ready_i  = 3'b000;
    accepted = 0;
    for (int k = 0; k < 6; k++) fullWords[k] = 32'h10203040 + k * 32'h01010101;
    for (int k = 0; k < 6; k++) begin
      select  = 2'(accepted % 3);
      data_i  = fullWords[accepted];
      valid_i = 1'b1;
      prevRdy = ready_o;
      @(posedge clk_sys);
      #1;
      if (prevRdy) begin
        pushWord(2'(accepted % 3), fullWords[accepted]);
        accepted++;
      end
    end
    valid_i = 1'b0;
    checkOutput("fullAccepted", accepted, 3);
    checkOutput("fullReadyLow", ready_o, 0);
    ready_i = 3'b111;
    prevRdy = ready_o;
    guard   = 0;
    while (hsLog.size() < 4 && guard < 50) begin
      prevRdy = ready_o;
      @(posedge clk_sys);
      #2;
      guard++;
    end
    if (hsLog.size() < 4) reportTimeout("fullFirstWord");
    checkOutput("fullReadyBeforePop", prevRdy, 0);
    checkOutput("fullReadyAfterPop", ready_o, 1);
    waitDrain("full");
    checkOutput("fullBeats", hsLog.size(), 12);
    if (hsLog.size() == 12) checkOutput("fullSpan", hsLog[11] - hsLog[0], 11);

    // Reset during the second beat.
    hsLog.delete();
    applyStimulus(2'd2, 32'h13579BDF, acc);
    guard = 0;
    while (hsLog.size() < 1 && guard < 50) begin
      @(posedge clk_sys);
      #2;
      guard++;
    end
    if (hsLog.size() < 1) reportTimeout("rstFirstBeat");
    checkOutput("secondBeatValid", valid_o, 3'b100);
    checkOutput("secondBeatData", data_o[23:16], 8'h57);
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("midRstValid", valid_o, 0);
    checkOutput("midRstData", data_o, 0);
    checkOutput("midRstReady", ready_o, 0);
    checkOutput("midRstBusy", busy_o, 0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    @(posedge clk_sys);
    #1;
    checkOutput("postRstReady", ready_o, 1);
    hsLog.delete();
    applyStimulus(2'd0, 32'h2468ACE0, acc);
    waitDrain("postRst");
    checkOutput("postRstBeats", hsLog.size(), 4);
    if (hsLog.size() == 4) checkOutput("postRstLatency", hsLog[0] - acc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Last-resort guard in case a wait is ever left unbounded.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
